// File: rtl/moving_average_pkg.sv
// Shared types and width helpers for the multi-channel moving-average filter.
package moving_average_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // A single channel still needs a one-bit tag so the ports never collapse.
  function automatic int ch_w(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

  function automatic int sum_w(input int data_w, input int win_pow);
    return data_w + win_pow;
  endfunction

endpackage

// File: rtl/moving_average_mc_if.sv
// Sample-in / average-out valid/ready bundle for moving_average_mc.
interface moving_average_mc_if #(
  parameter int DATA_W = 8,
  parameter int CH_W   = 1
);
  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;
  logic              out_full;

  modport master (
    output in_valid, in_ch, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_data, out_full
  );

  modport slave (
    input  in_valid, in_ch, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_data, out_full
  );
endinterface

// File: rtl/ma_window_ram.sv
// Per-channel sample window store: combinational read of the oldest slot,
// synchronous write, flushed by both reset and clear.
module ma_window_ram #(
  parameter int DATA_W = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [AW-1:0]     i_addr,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end
endmodule

// File: rtl/moving_average_mc.sv
// Multi-channel power-of-two moving-average filter with valid/ready handshake.
// Define MOVING_AVERAGE_ROUND_EN for round-half-up averages (truncating otherwise).
module moving_average_mc
  import moving_average_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int WIN_POW  = 2,
  parameter int CHANNELS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  moving_average_mc_if.slave  bus
);
  localparam int CH_W   = ch_w(CHANNELS);
  localparam int SUM_W  = sum_w(DATA_W, WIN_POW);
  localparam int RND_W  = SUM_W + 1;
  localparam int N      = 1 << WIN_POW;
  localparam int FILL_W = WIN_POW + 1;
  localparam int AW     = CH_W + WIN_POW;

  state_t            r_state, w_state_next;
  logic [CH_W-1:0]   r_ch;
  logic [DATA_W-1:0] r_data;
  logic [CH_W-1:0]   r_out_ch;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_full;

  logic              w_in_fire, w_ch_ok, w_upd;
  logic [SUM_W-1:0]  w_sum_all  [CHANNELS];
  logic [WIN_POW-1:0] w_wp_all  [CHANNELS];
  logic [FILL_W-1:0] w_fill_all [CHANNELS];
  logic [SUM_W-1:0]  w_sum_old, w_sum_new;
  logic [WIN_POW-1:0] w_wp_sel;
  logic [FILL_W-1:0] w_fill_sel, w_fill_new;
  logic [DATA_W-1:0] w_oldest, w_avg;

  assign bus.in_ready = (r_state == IDLE) && !clear;
  assign w_in_fire    = bus.in_valid && bus.in_ready;
  assign w_ch_ok      = (32'(r_ch) < CHANNELS);
  assign w_upd        = (r_state == UPDATE) && w_ch_ok && !clear;

  always_comb begin
    w_sum_old  = '0;
    w_wp_sel   = '0;
    w_fill_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_ch == CH_W'(c)) begin
        w_sum_old  = w_sum_all[c];
        w_wp_sel   = w_wp_all[c];
        w_fill_sel = w_fill_all[c];
      end
    end
  end

  // Running sum swaps the evicted sample for the new one; never wraps at SUM_W.
  assign w_sum_new  = w_sum_old - SUM_W'(w_oldest) + SUM_W'(r_data);
  assign w_fill_new = (w_fill_sel == FILL_W'(N)) ? w_fill_sel : w_fill_sel + FILL_W'(1);

`ifdef MOVING_AVERAGE_ROUND_EN
  logic [RND_W-1:0] w_rounded;
  assign w_rounded = {1'b0, w_sum_new} + RND_W'(N / 2);
  assign w_avg     = DATA_W'(w_rounded >> WIN_POW);
`else
  assign w_avg     = DATA_W'(w_sum_new >> WIN_POW);
`endif

  ma_window_ram #(.DATA_W(DATA_W), .AW(AW)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .i_addr  ({r_ch, w_wp_sel}),
    .i_we    (w_upd),
    .i_wdata (r_data),
    .o_rdata (w_oldest)
  );

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [SUM_W-1:0]   r_sum;
    logic [WIN_POW-1:0] r_wp;
    logic [FILL_W-1:0]  r_fill;
    logic               w_sel;

    assign w_sel = w_upd && (r_ch == CH_W'(gi));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sum  <= '0;
        r_wp   <= '0;
        r_fill <= '0;
      end else if (clear) begin
        r_sum  <= '0;
        r_wp   <= '0;
        r_fill <= '0;
      end else if (w_sel) begin
        r_sum  <= w_sum_new;
        r_wp   <= r_wp + WIN_POW'(1);
        r_fill <= w_fill_new;
      end
    end

    assign w_sum_all[gi]  = r_sum;
    assign w_wp_all[gi]   = r_wp;
    assign w_fill_all[gi] = r_fill;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_in_fire) w_state_next = UPDATE;
      UPDATE:  w_state_next = w_ch_ok ? EMIT : IDLE;
      EMIT:    if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (clear) w_state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ch       <= '0;
      r_data     <= '0;
      r_out_ch   <= '0;
      r_out_data <= '0;
      r_out_full <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_ch   <= bus.in_ch;
        r_data <= bus.in_data;
      end
      if (w_upd) begin
        r_out_ch   <= r_ch;
        r_out_data <= w_avg;
        r_out_full <= (w_fill_new == FILL_W'(N));
      end
    end
  end

  assign bus.out_valid = (r_state == EMIT);
  assign bus.out_ch    = r_out_ch;
  assign bus.out_data  = r_out_data;
  assign bus.out_full  = r_out_full;
endmodule

// File: tb/tb_moving_average_mc.sv
// Scoreboard bench for moving_average_mc: directed scenarios plus random traffic
// checked against a sample-history reference model.
module tb_moving_average_mc;
  import moving_average_pkg::*;

  localparam int DATA_W   = 8;
  localparam int WIN_POW  = 2;
  localparam int CHANNELS = 3;
  localparam int N        = 1 << WIN_POW;
  localparam int CH_W     = ch_w(CHANNELS);

  typedef struct {
    int ch;
    int data;
    int full;
    int hs;
    bit lat;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;

  moving_average_mc_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  moving_average_mc #(
    .DATA_W   (DATA_W),
    .WIN_POW  (WIN_POW),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   hist[CHANNELS][$];
  bit   rdy_rand = 1'b0;
  bit   lat_mode = 1'b1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Average of the last N samples of a channel, missing samples counting as zero.
  function automatic int ref_avg(input int s);
`ifdef MOVING_AVERAGE_ROUND_EN
    return (s + N / 2) / N;
`else
    return s / N;
`endif
  endfunction

  task automatic model_accept(input int ch, input int d, input int hs);
    exp_t e;
    int   s;
    int   sz;
    s = 0;
    hist[ch].push_back(d);
    sz = hist[ch].size();
    for (int k = (sz > N) ? sz - N : 0; k < sz; k++) s += hist[ch][k];
    e.ch   = ch;
    e.data = ref_avg(s);
    e.full = (sz >= N) ? 1 : 0;
    e.hs   = hs;
    e.lat  = lat_mode;
    exp_q.push_back(e);
  endtask

  task automatic model_flush();
    for (int c = 0; c < CHANNELS; c++) hist[c].delete();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bus.out_valid && bus.out_ready) begin
        $display("out ch=%0d data=%0d full=%0d", bus.out_ch, bus.out_data, bus.out_full);
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_ch", int'(bus.out_ch), e.ch);
          check("out_data", int'(bus.out_data), e.data);
          check("out_full", int'(bus.out_full), e.full);
          if (e.lat) check("latency", cyc - e.hs, 2);
        end
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(negedge clk);
      if (rdy_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int ch, input int d);
    int n;
    int hs;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_ch    = CH_W'(ch);
    bus.in_data  = DATA_W'(d);
    #1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      hs = cyc;
      if (ch < CHANNELS) model_accept(ch, d, hs);
      $display("in  ch=%0d data=%0d", ch, d);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!bus.out_valid && n < 20);
    check("out_valid_seen", int'(bus.out_valid), 1);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    exp_q.delete();
    #1;
    check("in_ready_during_clear", int'(bus.in_ready), 0);
    @(negedge clk);
    clear = 1'b0;
    model_flush();
    #1;
    check("out_valid_after_clear", int'(bus.out_valid), 0);
    check("in_ready_after_clear", int'(bus.in_ready), 1);
  endtask

  initial begin : stimulus
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_ch", int'(bus.out_ch), 0);
    check("rst_out_full", int'(bus.out_full), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    reset = 1'b0;

    // Steady value fills the window: early outputs are sum/N.
    for (int i = 0; i < 5; i++) send(0, 6);
    drain();
    pulse_clear();

    send(0, 200);
    send(1, 40);
    send(0, 200);
    drain();
    pulse_clear();

    for (int i = 0; i < 5; i++) send(1, 255);
    drain();
    pulse_clear();

    // Backpressure: held outputs, in_valid ignored while waiting.
    lat_mode      = 1'b0;
    bus.out_ready = 1'b0;
    send(2, 100);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = (i % 2 == 0);
      bus.in_ch    = CH_W'(0);
      bus.in_data  = DATA_W'(77);
      #1;
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_in_ready", int'(bus.in_ready), 0);
      if (exp_q.size() > 0) begin
        check("bp_out_data", int'(bus.out_data), exp_q[0].data);
        check("bp_out_ch", int'(bus.out_ch), exp_q[0].ch);
      end else begin
        check("bp_expected_pending", 0, 1);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    pulse_clear();

    // Clear while an average is waiting discards it.
    bus.out_ready = 1'b0;
    send(1, 50);
    wait_valid();
    pulse_clear();
    bus.out_ready = 1'b1;
    lat_mode      = 1'b1;
    send(0, 8);
    drain();

    // Reset mid-UPDATE after outputs hold non-zero values.
    for (int i = 0; i < 4; i++) send(1, 255);
    drain();
    send(2, 123);
    reset = 1'b1;
    exp_q.delete();
    model_flush();
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_out_data", int'(bus.out_data), 0);
    check("midrst_out_ch", int'(bus.out_ch), 0);
    check("midrst_out_full", int'(bus.out_full), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Out-of-range channel is swallowed.
    send(3, 99);
    check("drop_in_ready_t1", int'(bus.in_ready), 0);
    check("drop_out_valid_t1", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    check("drop_in_ready_t2", int'(bus.in_ready), 1);
    check("drop_out_valid_t2", int'(bus.out_valid), 0);
    repeat (2) @(negedge clk);

    // Random traffic across all channels, including the invalid one.
    lat_mode = 1'b0;
    rdy_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send($urandom_range(0, CHANNELS), $urandom_range(0, 255));
    end
    rdy_rand = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    drain();
    check("final_in_ready", int'(bus.in_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
